// File: rtl/mvu_out_collector.sv
// Collects PE result vectors into a first-word fall-through FIFO, narrows each lane and emits AXI-Stream rows.
// Optional lane saturation is enabled by defining MVU_OUT_SAT_EN; otherwise lanes are truncated.
module mvu_out_collector #(
   parameter int PE           = 4,
   parameter int TDstI        = 16,
   parameter int TDstO        = 8,
   parameter int OP_SGN       = 1,
   parameter int DEPTH        = 4,
   parameter int STALL_MARGIN = 2,
   parameter int NF           = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [PE-1:0]         i_in_v,
   input  logic [PE*TDstI-1:0]   i_in_dat,
   output logic                  o_stall,
   output logic                  o_m_axis_tvalid,
   input  logic                  i_m_axis_tready,
   output logic [PE*TDstO-1:0]   o_m_axis_tdata,
   output logic                  o_m_axis_tlast,
   output logic                  o_err_ovf,
   output logic                  o_err_lane
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = (NF > 1) ? $clog2(NF) : 1;
   localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
   localparam logic [CW-1:0] C_MARGIN = CW'(STALL_MARGIN);
   localparam logic [RW-1:0] C_LAST   = RW'(NF - 1);

`ifdef MVU_OUT_SAT_EN
   localparam logic [TDstI-1:0] C_SMAX = {TDstI{1'b1}} >> (TDstI - TDstO + 1);
   localparam logic [TDstI-1:0] C_SMIN = ~C_SMAX;
   localparam logic [TDstI-1:0] C_UMAX = {TDstI{1'b1}} >> (TDstI - TDstO);

   function automatic logic [TDstO-1:0] f_narrow(input logic [TDstI-1:0] v);
      logic [TDstI-1:0] c;
      c = v;
      if (OP_SGN != 0) begin
         if ($signed(v) > $signed(C_SMAX))      c = C_SMAX;
         else if ($signed(v) < $signed(C_SMIN)) c = C_SMIN;
         else                                   c = v;
      end else begin
         if (v > C_UMAX) c = C_UMAX;
         else            c = v;
      end
      return c[TDstO-1:0];
   endfunction
`else
   function automatic logic [TDstO-1:0] f_narrow(input logic [TDstI-1:0] v);
      return v[TDstO-1:0];
   endfunction

   // Upper lane bits and the signedness are irrelevant when truncating.
   logic w_unused;
   assign w_unused = ^{i_in_dat, OP_SGN != 0};
`endif

   logic [PE*TDstO-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wptr, r_rptr;
   logic [CW-1:0]       r_count;
   logic [RW-1:0]       r_row;
   logic                r_err_ovf, r_err_lane;
   logic [PE*TDstO-1:0] w_narrow;
   logic                w_wr, w_mixed, w_pop, w_full, w_push;

   assign w_wr    = &i_in_v;
   assign w_mixed = (|i_in_v) & ~w_wr;
   assign w_full  = (r_count == C_DEPTH);
   assign w_pop   = o_m_axis_tvalid & i_m_axis_tready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign w_push  = w_wr & (~w_full | w_pop);

   always_comb begin
      w_narrow = '0;
      for (int p = 0; p < PE; p++) begin
         w_narrow[p*TDstO +: TDstO] = f_narrow(i_in_dat[p*TDstI +: TDstI]);
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wptr] <= w_narrow;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_row      <= '0;
         r_err_ovf  <= 1'b0;
         r_err_lane <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop) r_row <= (r_row == C_LAST) ? '0 : r_row + RW'(1);
         r_err_ovf  <= r_err_ovf | (w_wr & w_full & ~w_pop);
         r_err_lane <= r_err_lane | w_mixed;
      end
   end

   assign o_m_axis_tvalid = (r_count != '0);
   assign o_m_axis_tdata  = r_mem[r_rptr];
   assign o_m_axis_tlast  = o_m_axis_tvalid & (r_row == C_LAST);
   assign o_stall         = (C_DEPTH - r_count) <= C_MARGIN;
   assign o_err_ovf       = r_err_ovf;
   assign o_err_lane      = r_err_lane;
endmodule

// File: tb/tb_mvu_out_collector.sv
// Randomized self-checking bench for mvu_out_collector against a queue-based reference model.
module tb_mvu_out_collector;
   localparam int PE = 4, TI = 16, TO = 8, DEPTH = 4, SM = 2, NF = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    in_v;
   logic [63:0]   in_dat;
   logic          tready;
   logic          stall, tvalid, tlast, err_ovf, err_lane;
   logic [31:0]   tdata;

   int n_chk = 0, n_fail = 0;
   bit armed = 1'b0;

   logic [31:0] q[$];
   int          row;
   bit          m_ovf, m_lane;
   logic [7:0]  tl_hist;
   int          pop_cnt;

   mvu_out_collector #(.PE(PE), .TDstI(TI), .TDstO(TO), .OP_SGN(1), .DEPTH(DEPTH),
                       .STALL_MARGIN(SM), .NF(NF)) dut (
      .i_clock(clk), .i_reset(rst), .i_in_v(in_v), .i_in_dat(in_dat),
      .o_stall(stall), .o_m_axis_tvalid(tvalid), .i_m_axis_tready(tready),
      .o_m_axis_tdata(tdata), .o_m_axis_tlast(tlast),
      .o_err_ovf(err_ovf), .o_err_lane(err_lane));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] narrow(input logic [63:0] d);
      logic [31:0] r;
      int v;
      r = 32'h0;
      for (int p = 0; p < PE; p++) begin
         v = int'($signed(d[p*16 +: 16]));
`ifdef MVU_OUT_SAT_EN
         if (v > 127)  v = 127;
         if (v < -128) v = -128;
`endif
         r[p*8 +: 8] = v[7:0];
      end
      return r;
   endfunction

   function automatic logic [63:0] vec(input logic [15:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic model_step();
      int  sz;
      bit  pop;
      if (tvalid === 1'b1 && tready) begin
         tl_hist = {tl_hist[6:0], tlast};
         pop_cnt++;
      end
      if (rst) begin
         q.delete();
         row = 0; m_ovf = 1'b0; m_lane = 1'b0;
      end else begin
         sz  = q.size();
         pop = (sz != 0) && tready;
         if (pop) begin
            void'(q.pop_front());
            row = (row == NF - 1) ? 0 : row + 1;
         end
         if (in_v == 4'hF) begin
            if (sz < DEPTH || pop) q.push_back(narrow(in_dat));
            else m_ovf = 1'b1;
         end else if (in_v != 4'h0) begin
            m_lane = 1'b1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison of all DUT outputs against the model.
   initial forever begin
      @(negedge clk);
      if (armed) begin
         chk("tvalid", {31'h0, tvalid}, {31'h0, q.size() != 0});
         chk("stall", {31'h0, stall}, {31'h0, (DEPTH - q.size()) <= SM});
         chk("tlast", {31'h0, tlast}, {31'h0, (q.size() != 0) && (row == NF - 1)});
         if (q.size() != 0) chk("tdata", tdata, q[0]);
         chk("err_ovf", {31'h0, err_ovf}, {31'h0, m_ovf});
         chk("err_lane", {31'h0, err_lane}, {31'h0, m_lane});
      end
   end

   task automatic drive(input logic [3:0] v, input logic [63:0] d, input logic r);
      @(negedge clk);
      rst = 1'b0; in_v = v; in_dat = d; tready = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_v = 4'h0; in_dat = 64'h0; tready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      armed = 1'b1;
   endtask

   initial begin
      rst = 1'b1; in_v = 4'h0; in_dat = 64'h0; tready = 1'b0;
      tl_hist = 8'h0; pop_cnt = 0; row = 0; m_ovf = 1'b0; m_lane = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();
      chk("rst_tvalid", {31'h0, tvalid}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_errs", {30'h0, err_ovf, err_lane}, 32'h0);

      // Single vector with latency one
      drive(4'hF, vec(16'd1, 16'd2, 16'd3, 16'd4), 1'b1);
      drive(4'h0, 64'h0, 1'b1);
      chk("single_tvalid", {31'h0, tvalid}, 32'h1);
      chk("single_tdata", tdata, 32'h04030201);
      chk("single_tlast", {31'h0, tlast}, 32'h0);

      // Row framing over six vectors
      do_reset();
      tl_hist = 8'h0; pop_cnt = 0;
      for (int i = 0; i < 6; i++) drive(4'hF, vec(16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3)), 1'b1);
      repeat (3) drive(4'h0, 64'h0, 1'b1);
      chk("row_pops", pop_cnt, 32'd6);
      chk("row_tlast", {26'h0, tl_hist[5:0]}, 32'h09);

      // Backpressure and stall
      do_reset();
      drive(4'hF, vec(16'h0011, 16'h0022, 16'h0033, 16'h0044), 1'b0);
      drive(4'hF, vec(16'h0055, 16'h0066, 16'h0077, 16'h0088), 1'b0);
      chk("bp_stall_1", {31'h0, stall}, 32'h0);
      drive(4'hF, vec(16'h0099, 16'h00AA, 16'h00BB, 16'h00CC), 1'b0);
      chk("bp_stall_2", {31'h0, stall}, 32'h1);
      chk("bp_hold_a", tdata, 32'h44332211);
      drive(4'h0, 64'h0, 1'b0);
      chk("bp_hold_b", tdata, 32'h44332211);
      repeat (4) drive(4'h0, 64'h0, 1'b1);
      chk("bp_drained", {31'h0, tvalid}, 32'h0);

      // Overflow drops the fifth vector
      do_reset();
      for (int i = 0; i < 5; i++) drive(4'hF, vec(16'(i * 16), 16'(i), 16'(i + 7), 16'(i + 9)), 1'b0);
      drive(4'h0, 64'h0, 1'b0);
      chk("ovf_flag", {31'h0, err_ovf}, 32'h1);
      pop_cnt = 0;
      repeat (6) drive(4'h0, 64'h0, 1'b1);
      chk("ovf_pops", pop_cnt, 32'd4);

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 4; i++) drive(4'hF, vec(16'(i + 1), 16'h0, 16'h0, 16'h0), 1'b0);
      drive(4'hF, vec(16'd5, 16'h0, 16'h0, 16'h0), 1'b1);
      drive(4'h0, 64'h0, 1'b0);
      chk("pp_ovf", {31'h0, err_ovf}, 32'h0);
      chk("pp_head", tdata, 32'h00000002);
      pop_cnt = 0;
      repeat (6) drive(4'h0, 64'h0, 1'b1);
      chk("pp_pops", pop_cnt, 32'd4);

      // Narrowing and lane mismatch
      do_reset();
      drive(4'hF, vec(16'h0190, 16'h0000, 16'hFF00, 16'h007F), 1'b0);
      drive(4'h0, 64'h0, 1'b0);
`ifdef MVU_OUT_SAT_EN
      chk("narrow", tdata, 32'h7F80007F);
`else
      chk("narrow", tdata, 32'h7F000090);
`endif
      drive(4'b0111, vec(16'd1, 16'd1, 16'd1, 16'd1), 1'b1);
      drive(4'h0, 64'h0, 1'b1);
      chk("lane_err", {31'h0, err_lane}, 32'h1);
      chk("lane_nowrite", {31'h0, tvalid}, 32'h0);

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int sel;
         logic [3:0] v;
         sel = $urandom_range(0, 19);
         v = (sel < 10) ? 4'hF : (sel < 19) ? 4'h0 : 4'($urandom_range(0, 15));
         drive(v, {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
         if ($urandom_range(0, 149) == 0) rst = 1'b1;
      end
      drive(4'h0, 64'h0, 1'b1);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
